// File: rtl/ioblock_cfg_pkg.sv
// Shared types and constants for the I/O-block configuration chain loader.
// Word layout: [2:1] TSMUX, [0] DORREG.
package ioblock_cfg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StShift,
    StUpdate
  } cfg_state_e;

  localparam int unsigned CFG_W_DEF  = 3;

  localparam int unsigned TSMUX_MSB  = 2;
  localparam int unsigned TSMUX_LSB  = 1;
  localparam int unsigned DORREG_BIT = 0;

  // TSMUX: 00 high-Z, 01 TS-gated drive, 1x always drive
  localparam logic [1:0] TSMUX_HIZ    = 2'b00;
  localparam logic [1:0] TSMUX_TSGATE = 2'b01;
  localparam logic [1:0] TSMUX_DRIVE  = 2'b10;

endpackage

// File: rtl/ioblock_cfg_ctrl_if.sv
// Host handshake and chain-side signals of the configuration loader.
interface ioblock_cfg_ctrl_if #(
  parameter int unsigned CFG_W = ioblock_cfg_pkg::CFG_W_DEF
);
  logic             START;
  logic             ABORT;
  logic [CFG_W-1:0] CFG_DATA;
  logic             CFG_VALID;
  logic             CFG_READY;
  logic             CFG_SOUT;
  logic             CFG_SEN;
  logic             CFG_UPD;
  logic             BUSY;
  logic             DONE;
  logic             ERR;

  modport master (
    output START, ABORT, CFG_DATA, CFG_VALID,
    input  CFG_READY, CFG_SOUT, CFG_SEN, CFG_UPD, BUSY, DONE, ERR
  );

  modport slave (
    input  START, ABORT, CFG_DATA, CFG_VALID,
    output CFG_READY, CFG_SOUT, CFG_SEN, CFG_UPD, BUSY, DONE, ERR
  );
endinterface

// File: rtl/ioblock_cfg_shifter.sv
// Parallel-load, MSB-first shift register with a down-counting bit index.
// o_last_bit is high while the final bit of the word is on o_sout.
module ioblock_cfg_shifter #(
  parameter int unsigned CFG_W = 3
) (
  input  logic             IOCLK,
  input  logic             RST_N,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [CFG_W-1:0] i_data,
  output logic             o_sout,
  output logic             o_last_bit
);
  localparam int unsigned     BitW    = (CFG_W > 1) ? $clog2(CFG_W) : 1;
  localparam logic [BitW-1:0] LastIdx = BitW'(CFG_W - 1);

  logic [CFG_W-1:0] r_shreg;
  logic [BitW-1:0]  r_bit_cnt;

  always_ff @(posedge IOCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
    end else if (i_load) begin
      r_shreg   <= i_data;
      r_bit_cnt <= LastIdx;
    end else if (i_shift) begin
      r_shreg <= r_shreg << 1;
      if (r_bit_cnt != '0) begin
        r_bit_cnt <= r_bit_cnt - 1'b1;
      end
    end
  end

  assign o_sout     = r_shreg[CFG_W-1];
  assign o_last_bit = (r_bit_cnt == '0);

endmodule

// File: rtl/ioblock_cfg_ctrl.sv
// Serial configuration loader: fetches one word per I/O block, shifts it onto
// the chain MSB-first and strobes a global update once all blocks are loaded.
module ioblock_cfg_ctrl
  import ioblock_cfg_pkg::*;
#(
  parameter int unsigned NUM_IOB = 32,
  parameter int unsigned CFG_W   = CFG_W_DEF
) (
  input logic               IOCLK,
  input logic               RST_N,
  ioblock_cfg_ctrl_if.slave bus
);
  localparam int unsigned      CNT_W    = (NUM_IOB > 1) ? $clog2(NUM_IOB) : 1;
  localparam logic [CNT_W-1:0] LastWord = CNT_W'(NUM_IOB - 1);

  cfg_state_e       r_state, w_state_next;
  logic [CNT_W-1:0] r_word_cnt, w_word_cnt_next;
  logic             r_err, w_err_next;
  logic             w_load, w_shift, w_sout, w_last_bit;

  ioblock_cfg_shifter #(
    .CFG_W (CFG_W)
  ) u_shifter (
    .IOCLK      (IOCLK),
    .RST_N      (RST_N),
    .i_load     (w_load),
    .i_shift    (w_shift),
    .i_data     (bus.CFG_DATA),
    .o_sout     (w_sout),
    .o_last_bit (w_last_bit)
  );

  always_ff @(posedge IOCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= StIdle;
      r_word_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_word_cnt <= w_word_cnt_next;
      r_err      <= w_err_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_word_cnt_next = r_word_cnt;
    w_err_next      = r_err;
    w_load          = 1'b0;
    w_shift         = 1'b0;
    // Abort beats any handshake; a word offered in the same cycle is dropped.
    if (r_state != StIdle && bus.ABORT) begin
      w_state_next = StIdle;
      w_err_next   = 1'b1;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.START) begin
            w_state_next    = StFetch;
            w_word_cnt_next = '0;
            w_err_next      = 1'b0;
          end
        end
        StFetch: begin
          if (bus.CFG_VALID) begin
            w_load       = 1'b1;
            w_state_next = StShift;
          end
        end
        StShift: begin
          w_shift = 1'b1;
          if (w_last_bit) begin
            if (r_word_cnt == LastWord) begin
              w_state_next = StUpdate;
            end else begin
              w_word_cnt_next = r_word_cnt + 1'b1;
              w_state_next    = StFetch;
            end
          end
        end
        StUpdate: begin
          w_state_next = StIdle;
        end
        default: begin
          w_state_next = StIdle;
        end
      endcase
    end
  end

  assign bus.CFG_READY = (r_state == StFetch);
  assign bus.CFG_SEN   = (r_state == StShift);
  assign bus.CFG_SOUT  = (r_state == StShift) & w_sout;
  assign bus.CFG_UPD   = (r_state == StUpdate);
  assign bus.DONE      = (r_state == StUpdate);
  assign bus.BUSY      = (r_state != StIdle);
  assign bus.ERR       = r_err;

endmodule

// File: tb/tb_ioblock_cfg_ctrl.sv
// Bench for ioblock_cfg_ctrl: a 4-block and a 1-block loader driven through one
// sequence, checked against a serial-chain model and load-latency arithmetic.
module tb_ioblock_cfg_ctrl;
  localparam int unsigned W      = 3;
  localparam int unsigned MAXN   = 4;
  localparam int          MaxCyc = 200;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         sel   = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         valid = 1'b0;
  logic [W-1:0] data  = '0;

  ioblock_cfg_ctrl_if #(.CFG_W(W)) if4 ();
  ioblock_cfg_ctrl_if #(.CFG_W(W)) if1 ();

  ioblock_cfg_ctrl #(.NUM_IOB(4), .CFG_W(W)) u_dut4 (
    .IOCLK (clk),
    .RST_N (rst_n),
    .bus   (if4.slave)
  );

  ioblock_cfg_ctrl #(.NUM_IOB(1), .CFG_W(W)) u_dut1 (
    .IOCLK (clk),
    .RST_N (rst_n),
    .bus   (if1.slave)
  );

  assign if4.START     = start & ~sel;
  assign if4.ABORT     = abort & ~sel;
  assign if4.CFG_VALID = valid & ~sel;
  assign if4.CFG_DATA  = data;
  assign if1.START     = start & sel;
  assign if1.ABORT     = abort & sel;
  assign if1.CFG_VALID = valid & sel;
  assign if1.CFG_DATA  = data;

  logic o_ready, o_sout, o_sen, o_upd, o_busy, o_done, o_err;
  logic [6:0] o_all;
  assign o_ready = sel ? if1.CFG_READY : if4.CFG_READY;
  assign o_sout  = sel ? if1.CFG_SOUT  : if4.CFG_SOUT;
  assign o_sen   = sel ? if1.CFG_SEN   : if4.CFG_SEN;
  assign o_upd   = sel ? if1.CFG_UPD   : if4.CFG_UPD;
  assign o_busy  = sel ? if1.BUSY      : if4.BUSY;
  assign o_done  = sel ? if1.DONE      : if4.DONE;
  assign o_err   = sel ? if1.ERR       : if4.ERR;
  assign o_all   = {o_ready, o_sout, o_sen, o_upd, o_busy, o_done, o_err};

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] g_words [MAXN];
  int           g_gaps  [MAXN];
  // Chain model: index 0 is the head; block b holds bits [b*W +: W].
  logic         chain_m  [2][MAXN*W];
  logic [W-1:0] live_m   [2][MAXN];
  logic [W-1:0] exp_live [2][MAXN];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic rand_words(input int max_gap);
    for (int i = 0; i < MAXN; i++) begin
      g_words[i] = W'($urandom);
      g_gaps[i]  = $urandom_range(0, max_gap);
    end
  endtask

  task automatic run_load(input bit one, input int abort_sen, input int rst_sen,
                          input bit start_noise, input bit abort_with_start);
    int s, n, cyc, sen_cnt, upd_cnt, done_cnt, upd_cyc, done_cyc, idx, gap_left, exp_upd;
    int chk_cyc, end_cyc, rel_cyc;
    bit aborted, was_reset, fin;
    logic [MAXN*W-1:0] got_stream, exp_stream;
    s = one ? 1 : 0;
    n = one ? 1 : MAXN;
    cyc = 0; sen_cnt = 0; upd_cnt = 0; done_cnt = 0; upd_cyc = -1; done_cyc = -1;
    idx = 0; chk_cyc = -1; end_cyc = -1; rel_cyc = -1;
    aborted = 1'b0; was_reset = 1'b0; fin = 1'b0;
    got_stream = '0;
    // Each word costs one FETCH cycle, its stall cycles and W SHIFT cycles.
    exp_upd    = 1;
    exp_stream = '0;
    for (int i = 0; i < n; i++) begin
      exp_upd    += 1 + g_gaps[i] + W;
      exp_stream = (exp_stream << W) | (MAXN*W)'(g_words[i]);
    end
    sel = one;
    @(negedge clk);
    start    = 1'b1;
    abort    = abort_with_start;
    valid    = 1'b0;
    gap_left = g_gaps[0];
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      abort = 1'b0;
      if (cyc == rel_cyc) rst_n = 1'b1;
      if (cyc == 1) begin
        check("busy_after_start", o_busy, 1);
        check("err_cleared_by_start", o_err, 0);
      end
      if (cyc == chk_cyc) begin
        check("abort_busy", o_busy, 0);
        check("abort_err", o_err, 1);
        check("abort_sen", o_sen, 0);
      end
      if (o_sen) begin
        got_stream = {got_stream[MAXN*W-2:0], o_sout};
        sen_cnt++;
        for (int i = n*W-1; i > 0; i--) chain_m[s][i] = chain_m[s][i-1];
        chain_m[s][0] = o_sout;
      end
      if (o_upd) begin
        upd_cnt++;
        upd_cyc = cyc;
        for (int b = 0; b < n; b++)
          for (int j = 0; j < W; j++) live_m[s][b][j] = chain_m[s][b*W+j];
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (aborted || was_reset) begin
        valid = 1'b0;
        if (cyc >= end_cyc) fin = 1'b1;
      end else if (upd_cyc > 0 && cyc > upd_cyc) begin
        check("busy_after_upd", o_busy, 0);
        fin = 1'b1;
      end else if (cyc > MaxCyc) begin
        check("load_timeout", cyc, MaxCyc);
        fin = 1'b1;
      end else begin
        if (abort_sen > 0 && o_sen && sen_cnt == abort_sen) begin
          abort   = 1'b1;
          aborted = 1'b1;
          chk_cyc = cyc + 1;
          end_cyc = cyc + 6;
        end
        if (rst_sen > 0 && o_sen && sen_cnt == rst_sen) begin
          #2 rst_n = 1'b0;
          #1 check("reset_async_outputs", o_all, 0);
          was_reset = 1'b1;
          rel_cyc   = cyc + 2;
          end_cyc   = cyc + 8;
        end
        if (o_busy && start_noise && $urandom_range(0, 2) == 0) start = 1'b1;
        if (o_ready && idx < n) begin
          if (gap_left > 0) begin
            valid = 1'b0;
            gap_left--;
          end else begin
            valid    = 1'b1;
            data     = g_words[idx];
            idx++;
            gap_left = (idx < n) ? g_gaps[idx] : 0;
          end
        end else begin
          valid = 1'($urandom_range(0, 1));
          data  = W'($urandom);
        end
      end
    end
    valid = 1'b0;
    if (aborted || was_reset) begin
      check("no_upd", upd_cnt, 0);
      check("no_done", done_cnt, 0);
      check(was_reset ? "err_after_reset" : "err_sticky", o_err, was_reset ? 0 : 1);
      for (int b = 0; b < n; b++) check("live_kept", live_m[s][b], exp_live[s][b]);
    end else begin
      check("sen_cycles", sen_cnt, n*W);
      check("stream", got_stream, exp_stream);
      check("upd_cycle", upd_cyc, exp_upd);
      check("done_cycle", done_cyc, exp_upd);
      check("upd_count", upd_cnt, 1);
      check("err_after_load", o_err, 0);
      // First word accepted lands in the block farthest from the head.
      for (int b = 0; b < n; b++) begin
        exp_live[s][b] = g_words[n-1-b];
        check("live_cfg", live_m[s][b], exp_live[s][b]);
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < MAXN*W; i++) chain_m[s][i] = 1'b0;
      for (int b = 0; b < MAXN; b++) begin
        live_m[s][b]   = '0;
        exp_live[s][b] = '0;
      end
    end
    repeat (2) @(negedge clk);
    sel = 1'b0;
    #1 check("reset_outputs_n4", o_all, 0);
    sel = 1'b1;
    #1 check("reset_outputs_n1", o_all, 0);
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed words 101,011,000,110: UPD at cycle 17, then with a 5-cycle stall (22).
    g_words = '{3'b101, 3'b011, 3'b000, 3'b110};
    g_gaps  = '{0, 0, 0, 0};
    run_load(1'b0, 0, 0, 1'b0, 1'b0);
    g_gaps  = '{0, 0, 5, 0};
    run_load(1'b0, 0, 0, 1'b0, 1'b0);

    // Abort on the second shift cycle of word 2.
    rand_words(0);
    run_load(1'b0, 5, 0, 1'b0, 1'b0);

    // Abort while idle must leave the sticky error alone.
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort_busy", o_busy, 0);
    check("idle_abort_err", o_err, 1);

    // START together with ABORT in idle is accepted and clears ERR.
    rand_words(2);
    run_load(1'b0, 0, 0, 1'b0, 1'b1);

    // START pulses while busy are ignored.
    rand_words(3);
    run_load(1'b0, 0, 0, 1'b1, 1'b0);

    // Reset mid-shift, then a clean load.
    rand_words(1);
    run_load(1'b0, 0, 7, 1'b0, 1'b0);
    rand_words(2);
    run_load(1'b0, 0, 0, 1'b0, 1'b0);

    // Single-block chain: UPD at cycle W+2 without stalls.
    rand_words(0);
    run_load(1'b1, 0, 0, 1'b0, 1'b0);
    rand_words(3);
    run_load(1'b1, 0, 0, 1'b1, 1'b0);
    rand_words(0);
    run_load(1'b1, 2, 0, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      rand_words(3);
      run_load(1'b0, 0, 0, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ioblock_cfg_ctrl.md
Name: ioblock_cfg_ctrl

Overview:
Serial configuration loader for a chain of NUM_IOB I/O blocks. Each I/O block holds per-pin configuration: TSMUX (2 bits, output/tristate select) and DORREG (1 bit, direct vs registered input). The controller accepts one configuration word per I/O block from the host or bitstream loader over a valid/ready handshake. It shifts each word MSB-first onto the chain, then pulses a global update strobe so that all blocks take their new configuration in the same cycle. It sits between the bitstream loader and the I/O ring.

Parameters:
NUM_IOB, 32, number of I/O blocks on the chain (>=1)
CFG_W, 3, config bits per I/O block; word [2:1]=TSMUX, [0]=DORREG
CNT_W, $clog2(NUM_IOB) (min 1), localparam, word counter width

Ports:
IOCLK      input   1      clock, rising edge
RST_N      input   1      asynchronous active-low reset
START      input   1      begin load; sampled in IDLE only
ABORT      input   1      cancel load in progress
CFG_DATA   input   CFG_W  config word for the next I/O block
CFG_VALID  input   1      CFG_DATA valid
CFG_READY  output  1      controller accepts CFG_DATA
CFG_SOUT   output  1      serial data to the chain head
CFG_SEN    output  1      chain shift enable; the chain shifts on IOCLK when high
CFG_UPD    output  1      one-cycle strobe: shadow -> live config in all blocks
BUSY       output  1      load in progress (state != IDLE)
DONE       output  1      one-cycle pulse on successful completion
ERR        output  1      sticky abort flag

Behaviour:
- Reset (RST_N low, async): state=IDLE, all outputs 0, counters 0, shift register 0, ERR=0.
- Outputs are Moore. They are decoded from registered state and registers, with no combinational input->output path.
- States and transitions:
  - IDLE: BUSY=0. START=1 -> FETCH; word_cnt=0; ERR cleared.
  - FETCH: CFG_READY=1. On CFG_VALID&CFG_READY, capture CFG_DATA into the shift register, set bit_cnt=CFG_W-1, go to SHIFT. With CFG_VALID low, stay in FETCH; CFG_SEN=0 and the chain holds.
  - SHIFT: CFG_SEN=1 and CFG_SOUT=shreg[CFG_W-1]. Shift left each cycle. When bit_cnt==0:
    - if word_cnt==NUM_IOB-1 -> UPDATE;
    - else word_cnt+1 -> FETCH.
  - UPDATE: CFG_UPD=1 and DONE=1 for exactly this cycle, then -> IDLE.
- Ordering: the first word accepted ends in the block farthest from the chain head (block NUM_IOB-1). The last word ends in block 0.
- Latency with VALID held high: NUM_IOB*(CFG_W+1) cycles of FETCH/SHIFT, then UPDATE. CFG_UPD is high in cycle NUM_IOB*(CFG_W+1)+1 after the START-sampling edge. CFG_SEN is high for exactly NUM_IOB*CFG_W cycles per load.
- START outside IDLE is ignored, with no effect on counters.
- ABORT in any non-IDLE state -> IDLE on the next edge and ERR=1. CFG_UPD and DONE are never asserted for that load, so live I/O config is unchanged. ABORT in IDLE is ignored.
- ABORT and a FETCH handshake in the same cycle: ABORT wins and the word is consumed and discarded.
- START and ABORT together in IDLE: START is accepted.
- ERR stays set until the next accepted START.
- Reset mid-load: immediate return to IDLE. CFG_UPD is never emitted and ERR=0.

Decomposition:
- Package ioblock_cfg_pkg holds:
  - state enum (IDLE, FETCH, SHIFT, UPDATE);
  - field positions TSMUX_MSB=2, TSMUX_LSB=1, DORREG_BIT=0;
  - TSMUX encodings: 00 high-Z, 01 TS-gated drive, 1x always drive;
  - default CFG_W.
- One sub-module, ioblock_cfg_shifter: load/shift register plus bit counter, exposing load, shift, sout and last_bit. The FSM and word counter stay in ioblock_cfg_ctrl.

Test Plan:
- NUM_IOB=4, CFG_W=3, VALID always high, words 101,011,000,110:
  - CFG_SOUT on SEN cycles = 1,0,1,0,1,1,0,0,0,1,1,0;
  - SEN high 12 cycles total;
  - CFG_UPD and DONE high together in cycle 17 after START, then BUSY=0.
- Backpressure: drop VALID for 5 cycles before word 3 -> READY held, SEN=0 those cycles, serial stream identical to the previous case, UPD at cycle 22.
- ABORT on the 2nd SHIFT cycle of word 2 -> IDLE next cycle, ERR=1, UPD/DONE never asserted. A following START clears ERR and completes a full load.
- START pulsed while BUSY in FETCH and in SHIFT -> no change in word_cnt or bit stream; single UPD at the expected cycle.
- RST_N low mid-SHIFT -> all outputs 0 asynchronously, no UPD. A subsequent clean load succeeds.
- NUM_IOB=1 -> CFG_W SEN cycles, then UPD at cycle CFG_W+2.
